// File: rtl/sprite_loader_if.sv
// Byte-stream input and storage write-port bundle for sprite_loader.
// master = the loader (drives in_ready and the write port); slave = stream source / storage side.
interface sprite_loader_if #(
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned ADDR_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic [SEL_W-1:0]  w_select;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  in_valid, in_data,
    output in_ready, w_select, w_en, w_addr, w_data, busy, done, err
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, w_select, w_en, w_addr, w_data, busy, done, err
  );
endinterface

// File: rtl/sprite_loader.sv
// Framed byte stream -> sprite_storage write port. One frame loads one sprite slot.
// Optional trailing XOR checksum byte enabled by defining SPRITE_LOADER_CHECKSUM_EN.
module sprite_loader #(
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned ADDR_W = 14
) (
  input logic             clock,
  input logic             reset_n,
  sprite_loader_if.master bus
);
  localparam int unsigned IdxW   = ADDR_W - 1;
  localparam int unsigned LenHiW = IdxW - 8;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
`ifdef SPRITE_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone
  } state_e;

  state_e              r_state, w_state_d;
  logic                r_rdy;
  logic [SEL_W-1:0]    r_sel, w_sel_d;
  logic                r_err, w_err_d;
  logic [LenHiW-1:0]   r_len_hi, w_len_hi_d;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_d;
  logic [IdxW-1:0]     r_idx, w_idx_d;
  logic                r_wen, w_wen_d;
  logic [ADDR_W-1:0]   r_waddr, w_waddr_d;
  logic [7:0]          r_wdata, w_wdata_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum, w_csum_d;
`endif
  logic                w_xfer;
  logic [IdxW-1:0]     w_len;

  assign bus.in_ready = r_rdy & (r_state != StDone);
  assign w_xfer       = bus.in_valid & bus.in_ready;
  assign w_len        = {r_len_hi, bus.in_data};

  always_comb begin
    w_state_d  = r_state;
    w_sel_d    = r_sel;
    w_err_d    = r_err;
    w_len_hi_d = r_len_hi;
    w_cnt_d    = r_cnt;
    w_idx_d    = r_idx;
    w_wen_d    = 1'b0;
    w_waddr_d  = r_waddr;
    w_wdata_d  = r_wdata;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    w_csum_d   = r_csum;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          if (bus.in_data[7:5] == 3'b101) begin
            w_sel_d   = bus.in_data[SEL_W-1:0];
            w_err_d   = 1'b0;
            w_state_d = StLenHi;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StLenHi: begin
        if (w_xfer) begin
          w_len_hi_d = bus.in_data[LenHiW-1:0];
          w_state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (w_xfer) begin
          // A zero length encodes a full sprite
          w_cnt_d   = (w_len == '0) ? {1'b1, {IdxW{1'b0}}} : {1'b0, w_len};
          w_idx_d   = '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
          w_csum_d  = '0;
`endif
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_xfer) begin
          w_wen_d   = 1'b1;
          w_waddr_d = {r_idx, 1'b0};
          w_wdata_d = bus.in_data;
          w_idx_d   = r_idx + 1'b1;
          w_cnt_d   = r_cnt - 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
          w_csum_d  = r_csum ^ bus.in_data;
          if (r_cnt == ADDR_W'(1)) w_state_d = StCsum;
`else
          if (r_cnt == ADDR_W'(1)) w_state_d = StDone;
`endif
        end
      end
`ifdef SPRITE_LOADER_CHECKSUM_EN
      StCsum: begin
        if (w_xfer) begin
          if (bus.in_data != r_csum) w_err_d = 1'b1;
          w_state_d = StDone;
        end
      end
`endif
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_rdy    <= 1'b0;
      r_sel    <= '0;
      r_err    <= 1'b0;
      r_len_hi <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_rdy    <= 1'b1;
      r_sel    <= w_sel_d;
      r_err    <= w_err_d;
      r_len_hi <= w_len_hi_d;
      r_cnt    <= w_cnt_d;
      r_idx    <= w_idx_d;
      r_wen    <= w_wen_d;
      r_waddr  <= w_waddr_d;
      r_wdata  <= w_wdata_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      r_csum   <= w_csum_d;
`endif
    end
  end

  assign bus.w_select = r_sel;
  assign bus.w_en     = r_wen;
  assign bus.w_addr   = r_waddr;
  assign bus.w_data   = r_wdata;
  assign bus.busy     = (r_state != StIdle);
  assign bus.done     = (r_state == StDone);
  assign bus.err      = r_err;
endmodule
